// File: rtl/vdma_rd_burst_master_pkg.sv
// Shared types and AXI constants for the VDMA read burst master.
package vdma_rd_burst_master_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    AR_ISSUE = 3'd1,
    R_WAIT   = 3'd2,
    FIN      = 3'd3,
    DRAIN    = 3'd4
  } RD_MST_STATE;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam int         AXI_4K         = 4096;

endpackage

// File: rtl/vdma_rd_burst_master_split.sv
// Next sub-burst length: smallest of remaining beats, the burst cap and
// the beats left before the current 4 KB page ends.
module rd_burst_split
  import vdma_rd_burst_master_pkg::*;
#(
  parameter int DATA_W    = 256,
  parameter int LSIZE     = 9,
  parameter int MAX_BEATS = 256
) (
  input  logic [11:0]      ptr_lo,
  input  logic [LSIZE-1:0] rem,
  output logic [8:0]       beats
);

  localparam int BSH = $clog2(DATA_W / 8);
  localparam int CW  = (LSIZE > 14) ? LSIZE : 14;

  function automatic logic [CW-1:0] clamp_min(input logic [CW-1:0] a, input logic [CW-1:0] b);
    return (a < b) ? a : b;
  endfunction

  logic [CW-1:0] to_4k;
  logic [CW-1:0] cap;

  // Page headroom in beats, then clamp by remaining length and burst cap
  always_comb begin
    to_4k = (CW'(AXI_4K) - CW'(ptr_lo)) >> BSH;
    cap   = clamp_min(clamp_min(CW'(rem), CW'(MAX_BEATS)), to_4k);
    beats = 9'(cap);
  end

endmodule

// File: rtl/vdma_rd_burst_master.sv
// AXI4 read burst master feeding the VDMA read FIFO. Serves one request at a
// time, split into INCR bursts that never cross 4 KB, one AR outstanding.
module vdma_rd_burst_master
  import vdma_rd_burst_master_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 256,
  parameter int ID_W      = 4,
  parameter int ARID_VAL  = 0,
  parameter int LSIZE     = 9,
  parameter int MAX_BEATS = 256
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              fsync,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              burst_req,
  input  logic              tail_req,
  input  logic [LSIZE-1:0]  req_len,
  output logic              resp,
  output logic              done,
  output logic              arvalid,
  input  logic              arready,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic [ID_W-1:0]   arid,
  input  logic              rvalid,
  output logic              rready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_wr_data,
  output logic              rd_err
);

  localparam int BSH = $clog2(DATA_W / 8);

  RD_MST_STATE       state, state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [LSIZE-1:0]  rem;
  logic [LSIZE-1:0]  rem_after;
  logic [8:0]        beats;
  logic [8:0]        beats_q;
  logic [8:0]        cnt;
  logic              abort_q;
  logic              accept;
  logic              beat;
  logic              cnt_last;
  logic              final_beat;
  logic              vld_p1;
  logic              err_p1;
  logic [DATA_W-1:0] data_p1;

  assign arsize  = 3'(BSH);
  assign arburst = AXI_BURST_INCR;
  assign arid    = ID_W'(ARID_VAL);

  assign accept     = (state == IDLE) && (burst_req || tail_req) && !fsync;
  assign beat       = rvalid && rready;
  assign cnt_last   = (cnt == 9'd1);
  assign final_beat = (state == R_WAIT) && beat && cnt_last;
  assign rem_after  = rem - LSIZE'(beats_q);

  rd_burst_split #(
    .DATA_W    (DATA_W),
    .LSIZE     (LSIZE),
    .MAX_BEATS (MAX_BEATS)
  ) u_split (
    .ptr_lo (ptr[11:0]),
    .rem    (rem),
    .beats  (beats)
  );

  // State register
  always_ff @(posedge clock) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; fsync aborts, but a pending AR must still complete
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = (req_len == '0) ? FIN : AR_ISSUE;
      end
      AR_ISSUE: begin
        if (!arvalid) begin
          if (fsync) state_nxt = IDLE;
        end else if (arready) begin
          state_nxt = (fsync || abort_q) ? DRAIN : R_WAIT;
        end
      end
      R_WAIT: begin
        if (fsync)           state_nxt = (beat && cnt_last) ? IDLE : DRAIN;
        else if (final_beat) state_nxt = (rem_after != '0) ? AR_ISSUE : FIN;
      end
      FIN:     state_nxt = IDLE;
      DRAIN: begin
        if (beat && cnt_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pointer, remaining length, AR channel registers and beat counter
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      ptr     <= '0;
      rem     <= '0;
      cnt     <= '0;
      beats_q <= '0;
      abort_q <= 1'b0;
      arvalid <= 1'b0;
      araddr  <= '0;
      arlen   <= '0;
      resp    <= 1'b0;
      done    <= 1'b0;
      rready  <= 1'b0;
    end else begin
      rready <= 1'b1;
      resp   <= accept;
      done   <= (state == FIN);

      if (fsync)           ptr <= base_addr;
      else if (final_beat) ptr <= ptr + (ADDR_W'(beats_q) << BSH);

      if (accept)          rem <= req_len;
      else if (final_beat) rem <= rem_after;

      if (state == AR_ISSUE) begin
        if (!arvalid) begin
          if (!fsync) begin
            arvalid <= 1'b1;
            araddr  <= ptr;
            arlen   <= 8'(beats - 9'd1);
            beats_q <= beats;
          end
        end else if (arready) begin
          arvalid <= 1'b0;
          abort_q <= 1'b0;
          cnt     <= beats_q;
        end else if (fsync) begin
          abort_q <= 1'b1;
        end
      end

      if ((state == R_WAIT || state == DRAIN) && beat && cnt != '0)
        cnt <= cnt - 9'd1;
    end
  end

  // Stage p1: registered FIFO write and error flag, aligned with each beat
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      err_p1  <= 1'b0;
      data_p1 <= '0;
    end else begin
      vld_p1  <= beat && (state != DRAIN);
      err_p1  <= beat && ((rresp != AXI_RESP_OKAY) ||
                 ((state == R_WAIT || state == DRAIN) && (rlast != cnt_last)));
      data_p1 <= rdata;
    end
  end

  assign fifo_wr_en   = vld_p1;
  assign fifo_wr_data = data_p1;
  assign rd_err       = err_p1;

endmodule

// File: tb/tb_vdma_rd_burst_master.sv
// Self-checking bench: randomized AXI slave plus a request-level model of
// burst splitting, pointer advance and completion timing.
module tb_vdma_rd_burst_master;

  localparam int BPB = 32;

  logic         clock = 1'b0;
  logic         rst_n = 1'b0;
  logic         fsync = 1'b0;
  logic [31:0]  base_addr = '0;
  logic         burst_req = 1'b0;
  logic         tail_req = 1'b0;
  logic [8:0]   req_len = '0;
  logic         arready = 1'b0;
  logic         rvalid = 1'b0;
  logic [255:0] rdata = '0;
  logic [1:0]   rresp = '0;
  logic         rlast = 1'b0;
  logic         resp, done, arvalid, rready, fifo_wr_en, rd_err;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic [3:0]   arid;
  logic [255:0] fifo_wr_data;

  vdma_rd_burst_master #(.ADDR_W(32), .DATA_W(256), .ID_W(4), .ARID_VAL(0),
                         .LSIZE(9), .MAX_BEATS(256)) dut (
    .clock(clock), .rst_n(rst_n), .fsync(fsync), .base_addr(base_addr),
    .burst_req(burst_req), .tail_req(tail_req), .req_len(req_len),
    .resp(resp), .done(done), .arvalid(arvalid), .arready(arready),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arid(arid), .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .rresp(rresp), .rlast(rlast), .fifo_wr_en(fifo_wr_en),
    .fifo_wr_data(fifo_wr_data), .rd_err(rd_err)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail = 0;

  // Observation and slave state
  logic [31:0]  ar_addr_q[$];
  logic [7:0]   ar_len_q[$];
  logic [255:0] wr_q[$];
  logic [255:0] sent_q[$];
  int pend_q[$];
  int cur_left = 0, beats_sent = 0;
  int stall_at = -1, resp_err_at = -1, drop_last_at = -1;
  int ar_block = 0;
  bit ar_rand = 1'b0;
  int cyc = 0, resp_cnt = 0, done_cnt = 0, err_cnt = 0, err_wr_idx = -1;
  int resp_cyc = 0, done_cyc = 0, last_wr_cyc = 0, av_cycles = 0;
  int ar_unstable = 0, ar_overlap = 0;
  logic        prev_av = 1'b0, prev_hs = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [7:0]  prev_len = '0;
  logic [31:0] model_ptr = '0;

  // Monitor and AXI slave: sample outputs, then drive the next cycle's inputs
  initial begin
    logic hs;
    forever begin
      @(negedge clock);
      cyc++;
      if (rst_n) begin
        if (fifo_wr_en) begin wr_q.push_back(fifo_wr_data); last_wr_cyc = cyc; end
        if (resp) begin resp_cnt++; resp_cyc = cyc; end
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (rd_err) begin err_cnt++; err_wr_idx = fifo_wr_en ? wr_q.size() : -1; end
        if (arvalid) av_cycles++;
        if (prev_av && !prev_hs &&
            (arvalid !== 1'b1 || araddr !== prev_addr || arlen !== prev_len)) ar_unstable++;
      end
      if (ar_block > 0) begin
        arready = 1'b0;
        if (arvalid) ar_block--;
      end else begin
        arready = ar_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      if (cur_left == 0 && pend_q.size() > 0) cur_left = pend_q.pop_front();
      if (cur_left > 0 && beats_sent != stall_at && $urandom_range(0, 3) != 0) begin
        rvalid = 1'b1;
        for (int k = 0; k < 8; k++) rdata[k*32 +: 32] = $urandom;
        rlast = (cur_left == 1) && (beats_sent != drop_last_at);
        rresp = (beats_sent == resp_err_at) ? 2'b10 : 2'b00;
      end else begin
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rdata = '0;
      end
      if (rvalid && rready) begin
        cur_left--; beats_sent++; sent_q.push_back(rdata);
      end
      hs = rst_n && arvalid && arready;
      if (hs) begin
        if (cur_left > 0 || pend_q.size() > 0) ar_overlap++;
        ar_addr_q.push_back(araddr);
        ar_len_q.push_back(arlen);
        pend_q.push_back(int'(arlen) + 1);
      end
      prev_av = arvalid; prev_addr = araddr; prev_len = arlen; prev_hs = hs;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_cycles(input int n);
    repeat (n) begin @(negedge clock); #1; end
  endtask

  task automatic clear_obs();
    ar_addr_q.delete(); ar_len_q.delete(); wr_q.delete(); sent_q.delete();
    resp_cnt = 0; done_cnt = 0; err_cnt = 0; err_wr_idx = -1; av_cycles = 0;
    ar_unstable = 0; ar_overlap = 0; last_wr_cyc = 0; done_cyc = 0; resp_cyc = 0;
  endtask

  task automatic do_fsync(input logic [31:0] b);
    @(negedge clock); #1; fsync = 1'b1; base_addr = b;
    @(negedge clock); #1; fsync = 1'b0; model_ptr = b;
  endtask

  // Full request against the model: split list, data order, completion timing
  task automatic run_request(input int len, input bit tail, input int exp_err);
    logic [31:0] ea[$];
    int el[$];
    logic [31:0] p;
    int r, b, to4k, t, bad, exp_done;
    p = model_ptr; r = len;
    while (r > 0) begin
      to4k = (4096 - int'(p & 32'hFFF)) / BPB;
      b = r;
      if (b > 256) b = 256;
      if (b > to4k) b = to4k;
      ea.push_back(p); el.push_back(b - 1);
      p = p + 32'(b * BPB); r -= b;
    end
    @(negedge clock); #1;
    clear_obs();
    req_len = 9'(len);
    if (tail) tail_req = 1'b1; else burst_req = 1'b1;
    @(negedge clock); #1;
    n_checks++; if (resp !== 1'b1) begin n_fail++; $display("FAIL resp_latency len=%0d: got %b want 1", len, resp); end
    burst_req = 1'b0; tail_req = 1'b0;
    t = 0;
    while (done_cnt == 0 && t < 3000) begin @(negedge clock); #1; t++; end
    if (done_cnt == 0) begin n_checks++; n_fail++; $display("FAIL done_timeout len=%0d: no done within 3000 cycles", len); end
    wait_cycles(3);
    n_checks++; if (resp_cnt !== 1) begin n_fail++; $display("FAIL resp_count len=%0d: got %0d want 1", len, resp_cnt); end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL done_count len=%0d: got %0d want 1", len, done_cnt); end
    n_checks++; if (ar_addr_q.size() !== ea.size()) begin n_fail++; $display("FAIL ar_count len=%0d: got %0d want %0d", len, ar_addr_q.size(), ea.size()); end
    for (int i = 0; i < ea.size() && i < ar_addr_q.size(); i++) begin
      n_checks++; if (ar_addr_q[i] !== ea[i] || int'(ar_len_q[i]) != el[i]) begin n_fail++;
        $display("FAIL ar_burst[%0d]: got addr %h len %0d want addr %h len %0d", i, ar_addr_q[i], ar_len_q[i], ea[i], el[i]); end
    end
    n_checks++; if (wr_q.size() !== len) begin n_fail++; $display("FAIL wr_count len=%0d: got %0d want %0d", len, wr_q.size(), len); end
    bad = -1;
    for (int i = 0; i < wr_q.size() && i < sent_q.size(); i++) if (bad < 0 && wr_q[i] !== sent_q[i]) bad = i;
    n_checks++; if (bad >= 0) begin n_fail++; $display("FAIL wr_data[%0d]: got %h want %h", bad, wr_q[bad], sent_q[bad]); end
    exp_done = (len == 0) ? resp_cyc + 1 : last_wr_cyc + 1;
    n_checks++; if (done_cyc !== exp_done) begin n_fail++; $display("FAIL done_align len=%0d: got cycle %0d want %0d", len, done_cyc, exp_done); end
    n_checks++; if (err_cnt !== exp_err) begin n_fail++; $display("FAIL rd_err_count len=%0d: got %0d want %0d", len, err_cnt, exp_err); end
    n_checks++; if (ar_overlap !== 0 || ar_unstable !== 0) begin n_fail++; $display("FAIL ar_protocol: overlap %0d unstable %0d want 0 0", ar_overlap, ar_unstable); end
    model_ptr = p;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wait_cycles(3);
    n_checks++; if ({arvalid, resp, done, fifo_wr_en, rd_err, rready} !== 6'b0) begin n_fail++;
      $display("FAIL reset_ctrl: got %b want 000000", {arvalid, resp, done, fifo_wr_en, rd_err, rready}); end
    n_checks++; if (araddr !== 32'h0 || arlen !== 8'h0 || fifo_wr_data !== 256'h0) begin n_fail++;
      $display("FAIL reset_data: got araddr %h arlen %h", araddr, arlen); end
    n_checks++; if (arsize !== 3'd5 || arburst !== 2'b01 || arid !== 4'd0) begin n_fail++;
      $display("FAIL reset_const: got size %0d burst %b id %0d want 5 01 0", arsize, arburst, arid); end
    rst_n = 1'b1;
    wait_cycles(1);
    n_checks++; if (rready !== 1'b1) begin n_fail++; $display("FAIL rready_after_reset: got %b want 1", rready); end
  endtask

  task automatic test_basic();
    do_fsync(32'h1000_0000);
    run_request(100, 1'b0, 0);
    n_checks++; if (ar_addr_q.size() < 1 || ar_addr_q[0] !== 32'h1000_0000 || ar_len_q[0] !== 8'd99) begin n_fail++;
      $display("FAIL basic_ar: got %0d bursts want one at 10000000 len 99", ar_addr_q.size()); end
    run_request(20, 1'b1, 0);
    n_checks++; if (ar_addr_q.size() < 1 || ar_addr_q[0] !== 32'h1000_0C80) begin n_fail++;
      $display("FAIL next_addr: got %h want 10000c80", (ar_addr_q.size() > 0) ? ar_addr_q[0] : 32'hx); end
  endtask

  task automatic test_split_4k();
    do_fsync(32'h1000_0000);
    run_request(300, 1'b0, 0);
    n_checks++; if (ar_addr_q.size() != 3 || ar_addr_q[1] !== 32'h1000_1000 || ar_len_q[2] !== 8'd43) begin n_fail++;
      $display("FAIL split_300: got %0d bursts want 3 with 2nd at 10001000 and last len 43", ar_addr_q.size()); end
  endtask

  task automatic test_4k_cross();
    do_fsync(32'h1000_0F00);
    run_request(20, 1'b0, 0);
    n_checks++; if (ar_addr_q.size() != 2 || ar_len_q[0] !== 8'd7 || ar_addr_q[1] !== 32'h1000_1000 || ar_len_q[1] !== 8'd11) begin n_fail++;
      $display("FAIL cross_4k: got %0d bursts want len 7 then len 11 at 10001000", ar_addr_q.size()); end
  endtask

  task automatic test_zero_len();
    run_request(0, 1'b1, 0);
    n_checks++; if (av_cycles !== 0) begin n_fail++; $display("FAIL zero_len_arvalid: got %0d cycles want 0", av_cycles); end
  endtask

  task automatic test_fsync_rwait();
    int start, t;
    do_fsync(32'h3000_0000);
    @(negedge clock); #1;
    clear_obs();
    start = beats_sent;
    stall_at = start + 40;
    req_len = 9'd100; burst_req = 1'b1;
    @(negedge clock); #1;
    burst_req = 1'b0;
    t = 0;
    while (beats_sent < start + 40 && t < 1000) begin @(negedge clock); #1; t++; end
    wait_cycles(2);
    do_fsync(32'h4000_0000);
    stall_at = -1;
    t = 0;
    while (beats_sent < start + 100 && t < 1000) begin @(negedge clock); #1; t++; end
    wait_cycles(4);
    n_checks++; if (beats_sent - start !== 100) begin n_fail++; $display("FAIL drain_beats: got %0d want 100", beats_sent - start); end
    n_checks++; if (wr_q.size() !== 40) begin n_fail++; $display("FAIL drain_writes: got %0d want 40", wr_q.size()); end
    n_checks++; if (done_cnt !== 0 || resp_cnt !== 1) begin n_fail++; $display("FAIL abort_pulses: got done %0d resp %0d want 0 1", done_cnt, resp_cnt); end
    run_request(10, 1'b0, 0);
    n_checks++; if (ar_addr_q.size() < 1 || ar_addr_q[0] !== 32'h4000_0000) begin n_fail++; $display("FAIL addr_after_abort: want 40000000"); end
  endtask

  task automatic test_fsync_ar_pending();
    int start, t;
    do_fsync(32'h5000_0000);
    @(negedge clock); #1;
    clear_obs();
    start = beats_sent;
    ar_block = 10;
    req_len = 9'd50; tail_req = 1'b1;
    @(negedge clock); #1;
    tail_req = 1'b0;
    t = 0;
    while (arvalid !== 1'b1 && t < 20) begin @(negedge clock); #1; t++; end
    wait_cycles(2);
    do_fsync(32'h6000_0000);
    t = 0;
    while ((ar_addr_q.size() == 0 || beats_sent < start + 50) && t < 1000) begin @(negedge clock); #1; t++; end
    wait_cycles(4);
    n_checks++; if (ar_addr_q.size() != 1 || ar_addr_q[0] !== 32'h5000_0000 || ar_len_q[0] !== 8'd49) begin n_fail++;
      $display("FAIL pending_ar: got %0d bursts want one at 50000000 len 49", ar_addr_q.size()); end
    n_checks++; if (ar_unstable !== 0 || av_cycles !== 11) begin n_fail++;
      $display("FAIL pending_ar_hold: got unstable %0d valid cycles %0d want 0 11", ar_unstable, av_cycles); end
    n_checks++; if (wr_q.size() !== 0 || done_cnt !== 0 || beats_sent - start !== 50) begin n_fail++;
      $display("FAIL pending_drain: got writes %0d done %0d beats %0d want 0 0 50", wr_q.size(), done_cnt, beats_sent - start); end
    run_request(10, 1'b1, 0);
    n_checks++; if (ar_addr_q.size() < 1 || ar_addr_q[0] !== 32'h6000_0000) begin n_fail++; $display("FAIL addr_after_pending: want 60000000"); end
  endtask

  task automatic test_rresp_err();
    do_fsync(32'h2000_0000);
    resp_err_at = beats_sent + 4;
    run_request(16, 1'b0, 1);
    resp_err_at = -1;
    n_checks++; if (err_wr_idx !== 5) begin n_fail++; $display("FAIL rd_err_align: got write %0d want 5", err_wr_idx); end
  endtask

  task automatic test_rlast_err();
    do_fsync(32'h2000_0000);
    drop_last_at = beats_sent + 15;
    run_request(16, 1'b1, 1);
    drop_last_at = -1;
  endtask

  task automatic test_random();
    logic [31:0] b;
    ar_rand = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) do_fsync(32'hFFFF_FFA0);
      else if ($urandom_range(0, 2) == 0) begin
        b = $urandom;
        do_fsync(b & 32'hFFFF_FFE0);
      end
      run_request($urandom_range(0, 300), 1'($urandom_range(0, 1)), 0);
    end
    ar_rand = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_split_4k();
    test_4k_cross();
    test_zero_len();
    test_fsync_rwait();
    test_fsync_ar_pending();
    test_rresp_err();
    test_rlast_err();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
